// File: rtl/eth_decap.sv
// Receive-side Ethernet/IPv4/UDP header parser for the 64-bit MAC RX stream.
// Emits a one-cycle header record per accepted frame and keeps frame statistics.
module eth_decap #(
  parameter logic [47:0] MAC_ADDR = 48'h00_11_22_33_44_55,
  parameter logic [15:0] UDP_PORT = 16'd3776
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        hdr_valid,
  output logic [47:0] hdr_src_mac,
  output logic [31:0] hdr_src_ip,
  output logic [31:0] hdr_dst_ip,
  output logic [15:0] hdr_src_port,
  output logic [15:0] hdr_udp_len,
  output logic [63:0] hdr_payload,
  output logic [31:0] rx_frames,
  output logic [31:0] rx_bad,
  output logic [31:0] rx_match
);

  typedef enum logic [1:0] {StSync, StIdle, StHdr, StBody} state_e;

  state_e      state_q;
  logic [2:0]  wcnt_q, idx;
  logic        match_q, match_d;
  logic        beat_ok, cap_en, w6_done, commit, accept;
  logic [63:0] be;

  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [15:0] src_port_q, src_port_d, udp_len_q, udp_len_d;
  logic [63:0] payload_q, payload_d;

  logic        hdr_valid_q;
  logic [47:0] hdr_src_mac_q;
  logic [31:0] hdr_src_ip_q, hdr_dst_ip_q;
  logic [15:0] hdr_src_port_q, hdr_udp_len_q;
  logic [63:0] hdr_payload_q;
  logic [31:0] rx_frames_q, rx_bad_q, rx_match_q;

  // Byte enables carry no parsing information.
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_tkeep;

  always_comb begin
    // Network-order view of the beat: frame byte 8k+0 lands in be[63:56].
    for (int n = 0; n < 8; n++) begin
      be[63-8*n -: 8] = s_axis_tdata[8*n +: 8];
    end
    idx        = (state_q == StIdle) ? 3'd0 : wcnt_q;
    cap_en     = s_axis_tvalid && (state_q == StIdle || state_q == StHdr);
    src_mac_d  = src_mac_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    src_port_d = src_port_q;
    udp_len_d  = udp_len_q;
    payload_d  = payload_q;
    beat_ok    = 1'b1;
    match_d    = match_q;
    if (cap_en) begin
      case (idx)
        3'd0: begin
          beat_ok = (be[63:16] == MAC_ADDR) || (be[63:16] == 48'hffff_ffff_ffff);
          src_mac_d[47:32] = be[15:0];
        end
        3'd1: begin
          src_mac_d[31:0] = be[63:32];
          beat_ok = (be[31:16] == 16'h0800) && (be[15:8] == 8'h45);
        end
        3'd2: beat_ok = (be[7:0] == 8'h11);
        3'd3: begin
          src_ip_d         = be[47:16];
          dst_ip_d[31:16]  = be[15:0];
        end
        3'd4: begin
          dst_ip_d[15:0] = be[63:48];
          src_port_d     = be[47:32];
          beat_ok        = (be[31:16] == UDP_PORT);
          udp_len_d      = be[15:0];
        end
        3'd5: payload_d[63:16] = be[47:0];
        3'd6: payload_d[15:0]  = be[63:48];
        default: ;
      endcase
      match_d = (state_q == StIdle) ? beat_ok : (match_q && beat_ok);
    end
    // A tlast on w6 itself still carries the full payload window.
    w6_done = (state_q == StBody) || (state_q == StHdr && wcnt_q == 3'd6);
    commit  = s_axis_tvalid && s_axis_tlast && (state_q != StSync);
    accept  = commit && s_axis_tuser && match_d && w6_done;
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q        <= StSync;
      wcnt_q         <= 3'd0;
      match_q        <= 1'b0;
      src_mac_q      <= '0;
      src_ip_q       <= '0;
      dst_ip_q       <= '0;
      src_port_q     <= '0;
      udp_len_q      <= '0;
      payload_q      <= '0;
      hdr_valid_q    <= 1'b0;
      hdr_src_mac_q  <= '0;
      hdr_src_ip_q   <= '0;
      hdr_dst_ip_q   <= '0;
      hdr_src_port_q <= '0;
      hdr_udp_len_q  <= '0;
      hdr_payload_q  <= '0;
      rx_frames_q    <= '0;
      rx_bad_q       <= '0;
      rx_match_q     <= '0;
    end else begin
      match_q     <= match_d;
      src_mac_q   <= src_mac_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      src_port_q  <= src_port_d;
      udp_len_q   <= udp_len_d;
      payload_q   <= payload_d;
      hdr_valid_q <= accept;
      if (accept) begin
        hdr_src_mac_q  <= src_mac_d;
        hdr_src_ip_q   <= src_ip_d;
        hdr_dst_ip_q   <= dst_ip_d;
        hdr_src_port_q <= src_port_d;
        hdr_udp_len_q  <= udp_len_d;
        hdr_payload_q  <= payload_d;
        rx_match_q     <= rx_match_q + 32'd1;
      end
      if (commit) begin
        rx_frames_q <= rx_frames_q + 32'd1;
        if (!s_axis_tuser) rx_bad_q <= rx_bad_q + 32'd1;
      end
      case (state_q)
        StSync: begin
          wcnt_q <= 3'd0;
          if (!s_axis_tvalid || s_axis_tlast) state_q <= StIdle;
        end
        StIdle: begin
          if (s_axis_tvalid && !s_axis_tlast) begin
            state_q <= StHdr;
            wcnt_q  <= 3'd1;
          end
        end
        default: begin
          if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
              state_q <= StIdle;
              wcnt_q  <= 3'd0;
            end else begin
              if (state_q == StHdr && wcnt_q == 3'd6) state_q <= StBody;
              if (wcnt_q != 3'd7) wcnt_q <= wcnt_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign hdr_valid    = hdr_valid_q;
  assign hdr_src_mac  = hdr_src_mac_q;
  assign hdr_src_ip   = hdr_src_ip_q;
  assign hdr_dst_ip   = hdr_dst_ip_q;
  assign hdr_src_port = hdr_src_port_q;
  assign hdr_udp_len  = hdr_udp_len_q;
  assign hdr_payload  = hdr_payload_q;
  assign rx_frames    = rx_frames_q;
  assign rx_bad       = rx_bad_q;
  assign rx_match     = rx_match_q;

endmodule

// File: tb/tb_eth_decap.sv
// Directed self-checking bench for eth_decap: filtering, gaps, back-to-back,
// mid-frame reset and counter wrap.
module tb_eth_decap;

  logic        clk156 = 1'b0;
  logic        eth_rst;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        hdr_valid;
  logic [47:0] hdr_src_mac;
  logic [31:0] hdr_src_ip, hdr_dst_ip;
  logic [15:0] hdr_src_port, hdr_udp_len;
  logic [63:0] hdr_payload;
  logic [31:0] rx_frames, rx_bad, rx_match;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_log[$];
  logic [7:0] fb [64];

  eth_decap dut (
    .clk156        (clk156),
    .eth_rst       (eth_rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .hdr_valid     (hdr_valid),
    .hdr_src_mac   (hdr_src_mac),
    .hdr_src_ip    (hdr_src_ip),
    .hdr_dst_ip    (hdr_dst_ip),
    .hdr_src_port  (hdr_src_port),
    .hdr_udp_len   (hdr_udp_len),
    .hdr_payload   (hdr_payload),
    .rx_frames     (rx_frames),
    .rx_bad        (rx_bad),
    .rx_match      (rx_match)
  );

  always #5 clk156 = ~clk156;
  always @(posedge clk156) cyc <= cyc + 1;
  always @(negedge clk156) if (hdr_valid === 1'b1) pulse_log.push_back(cyc);

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                             input logic [15:0] dport);
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) fb[i] = dmac[47-8*i -: 8];
    {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]} = 48'h02_aa_bb_cc_dd_ee;
    {fb[12], fb[13]} = etype;
    fb[14] = 8'h45;
    {fb[16], fb[17]} = 16'h002c;
    fb[22] = 8'h40;
    fb[23] = 8'h11;
    {fb[26], fb[27], fb[28], fb[29]} = 32'h0a00_0001;
    {fb[30], fb[31], fb[32], fb[33]} = 32'h0a00_0002;
    {fb[34], fb[35]} = 16'h04d2;
    {fb[36], fb[37]} = dport;
    {fb[38], fb[39]} = 16'h0018;
    for (int i = 0; i < 8; i++) fb[42+i] = 8'(i + 1);
  endtask

  // Optional one-cycle gaps before w3 and w6; rst_beat asserts eth_rst alongside that beat.
  task automatic drive_beats(input int nbeats, input logic user, input logic gaps,
                             input logic tail_idle, input int rst_beat);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && (k == 3 || k == 6)) begin
        @(negedge clk156);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        eth_rst       = 1'b0;
      end
      @(negedge clk156);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (k == nbeats - 1);
      s_axis_tuser  = (k == nbeats - 1) ? user : 1'b0;
      s_axis_tkeep  = 8'hff;
      eth_rst       = (k == rst_beat);
      for (int n = 0; n < 8; n++) s_axis_tdata[8*n +: 8] = fb[8*k + n];
    end
    if (tail_idle) begin
      @(negedge clk156);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      eth_rst       = 1'b0;
    end
  endtask

  task automatic do_reset();
    eth_rst       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = 8'h00;
    @(negedge clk156);
    @(negedge clk156);
    eth_rst = 1'b0;
    @(negedge clk156);
    pulse_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", hdr_valid); end
    checks++; if (rx_frames !== 32'd0) begin errors++; $display("FAIL reset_frames: got %h expected 0", rx_frames); end
    checks++; if (rx_bad !== 32'd0) begin errors++; $display("FAIL reset_bad: got %h expected 0", rx_bad); end
    checks++; if (rx_match !== 32'd0) begin errors++; $display("FAIL reset_match: got %h expected 0", rx_match); end
    checks++; if (hdr_payload !== 64'd0) begin errors++; $display("FAIL reset_payload: got %h expected 0", hdr_payload); end
    checks++; if (hdr_src_mac !== 48'd0) begin errors++; $display("FAIL reset_srcmac: got %h expected 0", hdr_src_mac); end
  endtask

  task automatic check_good_record(input string tag);
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", tag, hdr_valid); end
    checks++; if (hdr_src_mac !== 48'h02aa_bbcc_ddee) begin errors++; $display("FAIL %s_srcmac: got %h expected 02aabbccddee", tag, hdr_src_mac); end
    checks++; if (hdr_src_ip !== 32'h0a00_0001) begin errors++; $display("FAIL %s_srcip: got %h expected 0a000001", tag, hdr_src_ip); end
    checks++; if (hdr_dst_ip !== 32'h0a00_0002) begin errors++; $display("FAIL %s_dstip: got %h expected 0a000002", tag, hdr_dst_ip); end
    checks++; if (hdr_src_port !== 16'h04d2) begin errors++; $display("FAIL %s_srcport: got %h expected 04d2", tag, hdr_src_port); end
    checks++; if (hdr_udp_len !== 16'h0018) begin errors++; $display("FAIL %s_udplen: got %h expected 0018", tag, hdr_udp_len); end
    checks++; if (hdr_payload !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL %s_payload: got %h expected 0102030405060708", tag, hdr_payload); end
    checks++; if (rx_frames !== 32'd1) begin errors++; $display("FAIL %s_frames: got %0d expected 1", tag, rx_frames); end
    checks++; if (rx_match !== 32'd1) begin errors++; $display("FAIL %s_match: got %0d expected 1", tag, rx_match); end
    checks++; if (rx_bad !== 32'd0) begin errors++; $display("FAIL %s_bad: got %0d expected 0", tag, rx_bad); end
    @(negedge clk156);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse_width: got %b expected 0", tag, hdr_valid); end
    checks++; if (pulse_log.size() != 1) begin errors++; $display("FAIL %s_pulses: got %0d expected 1", tag, pulse_log.size()); end
  endtask

  task automatic test_match();
    do_reset();
    build_frame(48'h00_11_22_33_44_55, 16'h0800, 16'd3776);
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    check_good_record("match");
  endtask

  task automatic test_gaps();
    do_reset();
    build_frame(48'h00_11_22_33_44_55, 16'h0800, 16'd3776);
    drive_beats(8, 1'b1, 1'b1, 1'b1, -1);
    check_good_record("gaps");
  endtask

  task automatic test_filter();
    do_reset();
    build_frame(48'h00_11_22_33_44_55, 16'h0800, 16'd3776);
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    // Later frames carry a different payload so stale output fields are detectable.
    fb[42] = 8'hee;
    drive_beats(8, 1'b0, 1'b0, 1'b1, -1);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL bad_fcs_valid: got %b expected 0", hdr_valid); end
    checks++; if (rx_bad !== 32'd1) begin errors++; $display("FAIL bad_fcs_bad: got %0d expected 1", rx_bad); end
    checks++; if (rx_frames !== 32'd2) begin errors++; $display("FAIL bad_fcs_frames: got %0d expected 2", rx_frames); end
    checks++; if (hdr_payload !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL bad_fcs_hold: got %h expected 0102030405060708", hdr_payload); end
    build_frame(48'h00_11_22_33_44_55, 16'h0800, 16'd3777);
    fb[42] = 8'hee;
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL port_valid: got %b expected 0", hdr_valid); end
    build_frame(48'h00_11_22_33_44_55, 16'h0806, 16'd3776);
    fb[42] = 8'hee;
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL etype_valid: got %b expected 0", hdr_valid); end
    build_frame(48'h00_11_22_33_44_56, 16'h0800, 16'd3776);
    fb[42] = 8'hee;
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL mac_valid: got %b expected 0", hdr_valid); end
    checks++; if (rx_frames !== 32'd5) begin errors++; $display("FAIL filt_frames: got %0d expected 5", rx_frames); end
    checks++; if (rx_match !== 32'd1) begin errors++; $display("FAIL filt_match: got %0d expected 1", rx_match); end
    checks++; if (hdr_payload !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL filt_hold: got %h expected 0102030405060708", hdr_payload); end
    build_frame(48'hff_ff_ff_ff_ff_ff, 16'h0800, 16'd3776);
    fb[42] = 8'hee;
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL bcast_valid: got %b expected 1", hdr_valid); end
    checks++; if (hdr_payload !== 64'hee02_0304_0506_0708) begin errors++; $display("FAIL bcast_payload: got %h expected ee02030405060708", hdr_payload); end
    checks++; if (rx_match !== 32'd2) begin errors++; $display("FAIL bcast_match: got %0d expected 2", rx_match); end
    checks++; if (rx_frames !== 32'd6) begin errors++; $display("FAIL bcast_frames: got %0d expected 6", rx_frames); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    build_frame(48'h00_11_22_33_44_55, 16'h0800, 16'd3776);
    drive_beats(8, 1'b1, 1'b0, 1'b0, -1);
    drive_beats(8, 1'b1, 1'b0, 1'b0, -1);
    drive_beats(5, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL runt_valid: got %b expected 0", hdr_valid); end
    repeat (2) @(negedge clk156);
    checks++; if (pulse_log.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulse_log.size()); end
    if (pulse_log.size() >= 2) begin
      checks++; if (pulse_log[1] - pulse_log[0] != 8) begin errors++; $display("FAIL b2b_spacing: got %0d expected 8", pulse_log[1] - pulse_log[0]); end
    end
    checks++; if (rx_frames !== 32'd3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", rx_frames); end
    checks++; if (rx_match !== 32'd2) begin errors++; $display("FAIL b2b_match: got %0d expected 2", rx_match); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    build_frame(48'h00_11_22_33_44_55, 16'h0800, 16'd3776);
    drive_beats(8, 1'b1, 1'b0, 1'b1, 3);
    @(negedge clk156);
    checks++; if (rx_frames !== 32'd0) begin errors++; $display("FAIL midrst_frames: got %0d expected 0", rx_frames); end
    checks++; if (rx_bad !== 32'd0) begin errors++; $display("FAIL midrst_bad: got %0d expected 0", rx_bad); end
    checks++; if (rx_match !== 32'd0) begin errors++; $display("FAIL midrst_match: got %0d expected 0", rx_match); end
    checks++; if (pulse_log.size() != 0) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", pulse_log.size()); end
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL midrst_next_valid: got %b expected 1", hdr_valid); end
    checks++; if (rx_match !== 32'd1) begin errors++; $display("FAIL midrst_next_match: got %0d expected 1", rx_match); end
    checks++; if (rx_frames !== 32'd1) begin errors++; $display("FAIL midrst_next_frames: got %0d expected 1", rx_frames); end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.rx_frames_q = 32'hffff_ffff;
    @(negedge clk156);
    release dut.rx_frames_q;
    @(negedge clk156);
    checks++; if (rx_frames !== 32'hffff_ffff) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", rx_frames); end
    build_frame(48'h00_11_22_33_44_55, 16'h0800, 16'd3776);
    drive_beats(8, 1'b1, 1'b0, 1'b1, -1);
    checks++; if (rx_frames !== 32'd0) begin errors++; $display("FAIL wrap_frames: got %h expected 0", rx_frames); end
    checks++; if (rx_match !== 32'd1) begin errors++; $display("FAIL wrap_match: got %0d expected 1", rx_match); end
  endtask

  initial begin
    eth_rst       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = 8'h00;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    test_reset();
    test_match();
    test_filter();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (2) @(negedge clk156);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
